// File: rtl/pc_sequencer.sv
// ============================================================================
// pc_sequencer : registered fetch-stage PC with B/BR branch resolution,
//                stall buffering, taken-branch flush and HLT handling.
//                Optional BR_STATS_EN adds saturating taken/not-taken counters.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module pc_sequencer #(
  parameter int                 ADDR_W   = 16,
  parameter int                 IMM_W    = 9,
  parameter int                 INC      = 2,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              br_valid,
  input  logic              br_type,
  input  logic [2:0]        cond,
  input  logic [2:0]        flags,
  input  logic [IMM_W-1:0]  imm,
  input  logic [ADDR_W-1:0] reg_target,
  input  logic              halt,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus,
  output logic              taken,
  output logic              flush,
  output logic              halted,
  output logic              br_drop
`ifdef BR_STATS_EN
  ,
  output logic [15:0]       taken_cnt,
  output logic [15:0]       ntaken_cnt
`endif
);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               flush_q, flush_d;
  logic               drop_q, drop_d;
  logic               pend_valid_q, pend_valid_d;
  logic               pend_taken_q, pend_taken_d;
  logic [ADDR_W-1:0]  pend_target_q, pend_target_d;

  logic               cond_ok;
  logic [ADDR_W-1:0]  imm_off;
  logic [ADDR_W-1:0]  br_target;

  // flags = {Z,V,N}
  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      3'b000:  cond_ok = !flags[2];
      3'b001:  cond_ok = flags[2];
      3'b010:  cond_ok = !flags[2] && !flags[0];
      3'b011:  cond_ok = flags[0];
      3'b100:  cond_ok = flags[2] || (!flags[2] && !flags[0]);
      3'b101:  cond_ok = flags[0] || flags[2];
      3'b110:  cond_ok = flags[1];
      default: cond_ok = 1'b1;
    endcase
  end

  // Immediate counts instruction words; shift by one to get a byte offset.
  assign imm_off   = {{(ADDR_W-IMM_W-1){imm[IMM_W-1]}}, imm, 1'b0};
  assign pc_plus   = pc_q + ADDR_W'(INC);
  assign br_target = br_type ? reg_target : (pc_plus + imm_off);
  assign taken     = br_valid && cond_ok;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    flush_d       = 1'b0;
    drop_d        = drop_q;
    pend_valid_d  = pend_valid_q;
    pend_taken_d  = pend_taken_q;
    pend_target_d = pend_target_q;

    if (state_q == ST_RUN) begin
      if (stall) begin
        if (br_valid) begin
          if (!pend_valid_q) begin
            pend_valid_d  = 1'b1;
            pend_taken_d  = cond_ok;
            pend_target_d = br_target;
          end else begin
            drop_d = 1'b1;
          end
        end
      end else if (pend_valid_q) begin
        pc_d         = pend_taken_q ? pend_target_q : pc_plus;
        flush_d      = pend_taken_q;
        pend_valid_d = 1'b0;
        if (br_valid) begin
          drop_d = 1'b1;
        end
      end else if (taken) begin
        pc_d    = br_target;
        flush_d = 1'b1;
      end else if (halt) begin
        state_d = ST_HALTED;
      end else begin
        pc_d = pc_plus;
      end
    end else begin
      pend_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      flush_q       <= 1'b0;
      drop_q        <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_taken_q  <= 1'b0;
      pend_target_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      flush_q       <= flush_d;
      drop_q        <= drop_d;
      pend_valid_q  <= pend_valid_d;
      pend_taken_q  <= pend_taken_d;
      pend_target_q <= pend_target_d;
    end
  end

  assign pc      = pc_q;
  assign flush   = flush_q;
  assign halted  = (state_q == ST_HALTED);
  assign br_drop = drop_q;

`ifdef BR_STATS_EN
  logic        run_apply;
  logic        t_inc, n_inc;
  logic [15:0] taken_cnt_q, taken_cnt_d;
  logic [15:0] ntaken_cnt_q, ntaken_cnt_d;

  // A not-taken request coinciding with halt is never applied, so not counted.
  always_comb begin
    run_apply    = (state_q == ST_RUN) && !stall;
    t_inc        = run_apply && (pend_valid_q ? pend_taken_q : taken);
    n_inc        = run_apply && (pend_valid_q ? !pend_taken_q
                                              : (br_valid && !taken && !halt));
    taken_cnt_d  = taken_cnt_q;
    ntaken_cnt_d = ntaken_cnt_q;
    if (t_inc && (taken_cnt_q != 16'hFFFF)) begin
      taken_cnt_d = taken_cnt_q + 16'd1;
    end
    if (n_inc && (ntaken_cnt_q != 16'hFFFF)) begin
      ntaken_cnt_d = ntaken_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      taken_cnt_q  <= '0;
      ntaken_cnt_q <= '0;
    end else begin
      taken_cnt_q  <= taken_cnt_d;
      ntaken_cnt_q <= ntaken_cnt_d;
    end
  end

  assign taken_cnt  = taken_cnt_q;
  assign ntaken_cnt = ntaken_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed scenarios plus randomized traffic
// checked against a queue-based behavioural model.
`default_nettype none

module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        br_valid = 1'b0;
  logic        br_type = 1'b0;
  logic [2:0]  cond = '0;
  logic [2:0]  flags = '0;
  logic [8:0]  imm = '0;
  logic [15:0] reg_target = '0;
  logic        halt = 1'b0;
  logic [15:0] pc, pc_plus;
  logic        taken, flush, halted, br_drop;
  logic [15:0] taken_cnt, ntaken_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_sequencer #(
    .ADDR_W(16), .IMM_W(9), .INC(2), .RESET_PC(16'h0000)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .br_valid(br_valid),
    .br_type(br_type), .cond(cond), .flags(flags), .imm(imm),
    .reg_target(reg_target), .halt(halt), .pc(pc), .pc_plus(pc_plus),
    .taken(taken), .flush(flush), .halted(halted), .br_drop(br_drop)
`ifdef BR_STATS_EN
    , .taken_cnt(taken_cnt), .ntaken_cnt(ntaken_cnt)
`endif
  );

`ifndef BR_STATS_EN
  assign taken_cnt  = '0;
  assign ntaken_cnt = '0;
`endif

  // ---------------- behavioural reference model ----------------
  typedef struct {
    bit          t;
    logic [15:0] tgt;
  } pend_t;

  pend_t       pend_q[$];
  logic [15:0] m_pc;
  bit          m_flush, m_halted, m_drop;
  int          m_tcnt, m_ncnt;

  function automatic bit cond_ok(input logic [2:0] c, input logic [2:0] f);
    bit z, v, n;
    z = f[2]; v = f[1]; n = f[0];
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || (!z && !n);
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [15:0] b_target(input logic [15:0] p, input logic [8:0] im);
    int off;
    off = im[8] ? int'(im) - 512 : int'(im);
    return 16'(int'(p) + 2 + 2 * off);
  endfunction

  task automatic model_update();
    bit          t;
    logic [15:0] tgt;
    pend_t       p;
    if (rst) begin
      m_pc = 16'h0000; m_flush = 0; m_halted = 0; m_drop = 0;
      m_tcnt = 0; m_ncnt = 0; pend_q.delete();
      return;
    end
    if (m_halted) begin
      m_flush = 0; pend_q.delete();
      return;
    end
    t   = br_valid && cond_ok(cond, flags);
    tgt = br_type ? reg_target : b_target(m_pc, imm);
    if (stall) begin
      m_flush = 0;
      if (br_valid) begin
        if (pend_q.size() == 0) pend_q.push_back('{t: t, tgt: tgt});
        else m_drop = 1;
      end
    end else if (pend_q.size() != 0) begin
      p = pend_q.pop_front();
      m_pc    = p.t ? p.tgt : 16'(m_pc + 2);
      m_flush = p.t;
      if (p.t) begin if (m_tcnt < 65535) m_tcnt++; end
      else     begin if (m_ncnt < 65535) m_ncnt++; end
      if (br_valid) m_drop = 1;
    end else if (t) begin
      m_pc = tgt; m_flush = 1;
      if (m_tcnt < 65535) m_tcnt++;
    end else if (halt) begin
      m_halted = 1; m_flush = 0;
    end else begin
      m_pc = 16'(m_pc + 2); m_flush = 0;
      if (br_valid && m_ncnt < 65535) m_ncnt++;
    end
  endtask

  // ---------------- stimulus primitives ----------------
  task automatic drive(input logic s, input logic bv, input logic bt,
                       input logic [2:0] c, input logic [2:0] f,
                       input logic [8:0] im, input logic [15:0] rt, input logic h);
    @(negedge clk);
    rst = 0; stall = s; br_valid = bv; br_type = bt; cond = c; flags = f;
    imm = im; reg_target = rt; halt = h;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic step(input logic s, input logic bv, input logic bt,
                      input logic [2:0] c, input logic [2:0] f,
                      input logic [8:0] im, input logic [15:0] rt, input logic h);
    drive(s, bv, bt, c, f, im, rt, h);
    tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; stall = 0; br_valid = 0; halt = 0;
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 3'd0, 3'd0, 9'd0, 16'd0, 0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    checks++;
    if (pc !== 16'h0000 || flush !== 1'b0 || halted !== 1'b0 || br_drop !== 1'b0) begin
      errors++;
      $display("FAIL reset: pc=%h flush=%b halted=%b br_drop=%b, want 0000/0/0/0",
               pc, flush, halted, br_drop);
    end
    for (int i = 1; i <= 4; i++) begin
      idle(1);
      checks++;
      if (pc !== 16'(2 * i) || flush !== 1'b0 || halted !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle[%0d]: pc=%h flush=%b halted=%b, want pc=%h 0/0",
                 i, pc, flush, halted, 16'(2 * i));
      end
    end
  endtask

  task automatic test_cond_exhaustive();
    logic [15:0] exp_pc;
    bit          exp_t;
    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 8; f++) begin
        do_reset();
        idle(8);
        drive(0, 1, 0, 3'(c), 3'(f), 9'h003, 16'h0000, 0);
        #1;
        exp_t = cond_ok(3'(c), 3'(f));
        checks++;
        if (taken !== exp_t) begin
          errors++;
          $display("FAIL cond_taken c=%0d f=%0d: taken=%b want %b", c, f, taken, exp_t);
        end
        tick();
        exp_pc = exp_t ? 16'h0018 : 16'h0012;
        checks++;
        if (pc !== exp_pc || flush !== exp_t) begin
          errors++;
          $display("FAIL cond_branch c=%0d f=%0d: pc=%h flush=%b want pc=%h flush=%b",
                   c, f, pc, flush, exp_pc, exp_t);
        end
      end
    end
  endtask

  task automatic test_stall_br();
    do_reset();
    idle(2);
    step(1, 1, 1, 3'd7, 3'd0, 9'd0, 16'h111F, 0);
    step(1, 0, 0, 3'd0, 3'd0, 9'd0, 16'h0000, 0);
    step(1, 0, 0, 3'd0, 3'd0, 9'd0, 16'h0000, 0);
    checks++;
    if (pc !== 16'h0004 || flush !== 1'b0) begin
      errors++;
      $display("FAIL stall_hold: pc=%h flush=%b want 0004/0", pc, flush);
    end
    idle(1);
    checks++;
    if (pc !== 16'h111F || flush !== 1'b1) begin
      errors++;
      $display("FAIL stall_apply: pc=%h flush=%b want 111F/1", pc, flush);
    end
    idle(1);
    checks++;
    if (pc !== 16'h1121 || flush !== 1'b0) begin
      errors++;
      $display("FAIL stall_after: pc=%h flush=%b want 1121/0", pc, flush);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    step(0, 1, 1, 3'd7, 3'd0, 9'd0, 16'hFFFE, 0);
    step(0, 1, 0, 3'd7, 3'd0, 9'h1FF, 16'h0000, 0);
    checks++;
    if (pc !== 16'hFFFE || flush !== 1'b1) begin
      errors++;
      $display("FAIL wrap_branch: pc=%h flush=%b want FFFE/1", pc, flush);
    end
    idle(1);
    checks++;
    if (pc !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_seq: pc=%h want 0000", pc);
    end
  endtask

  task automatic test_halt();
    do_reset();
    idle(2);
    step(0, 0, 0, 3'd0, 3'd0, 9'd0, 16'h0000, 1);
    checks++;
    if (pc !== 16'h0004 || halted !== 1'b1) begin
      errors++;
      $display("FAIL halt_enter: pc=%h halted=%b want 0004/1", pc, halted);
    end
    step(0, 1, 1, 3'd7, 3'd0, 9'd0, 16'h1234, 0);
    step(1, 1, 0, 3'd7, 3'd0, 9'h010, 16'h0000, 1);
    idle(2);
    checks++;
    if (pc !== 16'h0004 || halted !== 1'b1 || flush !== 1'b0) begin
      errors++;
      $display("FAIL halt_frozen: pc=%h halted=%b flush=%b want 0004/1/0", pc, halted, flush);
    end
    do_reset();
    checks++;
    if (pc !== 16'h0000 || halted !== 1'b0) begin
      errors++;
      $display("FAIL halt_reset: pc=%h halted=%b want 0000/0", pc, halted);
    end
  endtask

  task automatic test_double_drop();
    do_reset();
    step(1, 1, 1, 3'd7, 3'd0, 9'd0, 16'h0200, 0);
    step(1, 1, 1, 3'd7, 3'd0, 9'd0, 16'h0300, 0);
    checks++;
    if (br_drop !== 1'b1 || pc !== 16'h0000) begin
      errors++;
      $display("FAIL drop_flag: br_drop=%b pc=%h want 1/0000", br_drop, pc);
    end
    idle(1);
    checks++;
    if (pc !== 16'h0200 || flush !== 1'b1 || br_drop !== 1'b1) begin
      errors++;
      $display("FAIL drop_apply: pc=%h flush=%b br_drop=%b want 0200/1/1", pc, flush, br_drop);
    end
`ifdef BR_STATS_EN
    checks++;
    if (taken_cnt !== 16'd1 || ntaken_cnt !== 16'd0) begin
      errors++;
      $display("FAIL drop_stats: taken_cnt=%0d ntaken_cnt=%0d want 1/0", taken_cnt, ntaken_cnt);
    end
`endif
  endtask

  task automatic test_random();
    bit exp_t;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, 1'($urandom),
            3'($urandom), 3'($urandom), 9'($urandom), 16'($urandom),
            $urandom_range(0, 49) == 0);
      rst = ($urandom_range(0, 79) == 0);
      #1;
      exp_t = br_valid && cond_ok(cond, flags);
      checks++;
      if (taken !== exp_t || pc_plus !== 16'(m_pc + 2)) begin
        errors++;
        $display("FAIL rand_comb[%0d]: taken=%b pc_plus=%h want %b/%h",
                 i, taken, pc_plus, exp_t, 16'(m_pc + 2));
      end
      tick();
      checks++;
      if (pc !== m_pc || flush !== m_flush || halted !== m_halted || br_drop !== m_drop) begin
        errors++;
        $display("FAIL rand_state[%0d]: pc=%h flush=%b halted=%b drop=%b want %h/%b/%b/%b",
                 i, pc, flush, halted, br_drop, m_pc, m_flush, m_halted, m_drop);
      end
`ifdef BR_STATS_EN
      checks++;
      if (taken_cnt !== 16'(m_tcnt) || ntaken_cnt !== 16'(m_ncnt)) begin
        errors++;
        $display("FAIL rand_stats[%0d]: taken_cnt=%0d ntaken_cnt=%0d want %0d/%0d",
                 i, taken_cnt, ntaken_cnt, m_tcnt, m_ncnt);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_cond_exhaustive();
    test_stall_br();
    test_wrap();
    test_halt();
    test_double_drop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
